// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and segment-pattern constants for the seven-segment
// reader. Segment order is A..G with A = bit 6 and G = bit 0, 1 = lit.
package seg7_pkg;

    // Decoded value: 0..9 for decimal digits, 10..15 for optional hex letters.
    typedef logic [3:0] digit_t;

    // IDLE: no result held. HOLD: a result is presented with out_valid = 1.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [6:0] PAT_BLANK = 7'b0000000;
    localparam logic [6:0] PAT_0     = 7'b1111110;
    localparam logic [6:0] PAT_1     = 7'b0110000;
    localparam logic [6:0] PAT_2     = 7'b1101101;
    localparam logic [6:0] PAT_3     = 7'b1111001;
    localparam logic [6:0] PAT_4     = 7'b0110011;
    localparam logic [6:0] PAT_5     = 7'b1011011;
    localparam logic [6:0] PAT_6     = 7'b1011111;
    localparam logic [6:0] PAT_7     = 7'b1110000;
    // Alternate 7 with segment G lit, produced by the in-house display driver.
    localparam logic [6:0] PAT_7_ALT = 7'b1110001;
    localparam logic [6:0] PAT_8     = 7'b1111111;
    localparam logic [6:0] PAT_9     = 7'b1111011;

    localparam logic [6:0] PAT_HEX_A = 7'b1110111;
    localparam logic [6:0] PAT_HEX_B = 7'b0011111;
    localparam logic [6:0] PAT_HEX_C = 7'b1001110;
    localparam logic [6:0] PAT_HEX_D = 7'b0111101;
    localparam logic [6:0] PAT_HEX_E = 7'b1001111;
    localparam logic [6:0] PAT_HEX_F = 7'b1000111;

endpackage

// File: rtl/seg7_reader_if.sv
// seg7_reader_if: result handshake from the reader to its consumer.
// master = reader side, slave = consumer side.
interface seg7_reader_if;
    import seg7_pkg::*;

    logic   out_valid;
    logic   out_ready;
    digit_t digit;
    logic   out_err;
    logic   overrun;

    modport master (
        output out_valid,
        output digit,
        output out_err,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  digit,
        input  out_err,
        input  overrun,
        output out_ready
    );

endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational segment-pattern to digit lookup.
// Optional macro SEG7_READER_HEX_EN adds the hex letters A..F (10..15);
// without it those patterns are reported illegal like any other unknown code.
// The blank pattern is reported illegal here; the reader filters it out
// before it can be emitted.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output digit_t     digit,
    output logic       illegal
);

    // Table lookup; unknown patterns give digit 0 with illegal set.
    always_comb begin
        digit   = 4'd0;
        illegal = 1'b0;
        case (pattern)
            PAT_0:     digit = 4'd0;
            PAT_1:     digit = 4'd1;
            PAT_2:     digit = 4'd2;
            PAT_3:     digit = 4'd3;
            PAT_4:     digit = 4'd4;
            PAT_5:     digit = 4'd5;
            PAT_6:     digit = 4'd6;
            PAT_7:     digit = 4'd7;
            PAT_7_ALT: digit = 4'd7;
            PAT_8:     digit = 4'd8;
            PAT_9:     digit = 4'd9;
`ifdef SEG7_READER_HEX_EN
            PAT_HEX_A: digit = 4'd10;
            PAT_HEX_B: digit = 4'd11;
            PAT_HEX_C: digit = 4'd12;
            PAT_HEX_D: digit = 4'd13;
            PAT_HEX_E: digit = 4'd14;
            PAT_HEX_F: digit = 4'd15;
`endif
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: samples a seven-segment bus, waits for STABLE_CYCLES identical
// samples, decodes the qualified pattern and offers it on a valid/ready
// handshake with a one-entry result buffer.
// Optional macro SEG7_READER_HEX_EN (in seg7_pattern_decode) enables hex A..F.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg,
    seg7_reader_if.master        out_if
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic [6:0] seg_q;
    logic [7:0] cnt_reg;
    logic       done_reg;     // counter was already saturated last cycle
    logic       qual;
    logic       emit;
    digit_t     dec_digit;
    logic       dec_illegal;

    state_t     state_reg;
    logic       valid_reg;
    digit_t     digit_reg;
    logic       err_reg;
    logic       overrun_reg;

    seg7_pattern_decode u_decode (
        .pattern (seg_q),
        .digit   (dec_digit),
        .illegal (dec_illegal)
    );

    // Qualify only on the first cycle at saturation so a held pattern fires once.
    assign qual = (cnt_reg == STABLE_MAX) && !done_reg;
    // A qualified blank produces nothing; the next stable pattern qualifies anew.
    assign emit = qual && (seg_q != PAT_BLANK);

    // Sample stage and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q    <= 7'd0;
            cnt_reg  <= 8'd0;
            done_reg <= 1'b0;
        end else begin
            seg_q    <= seg;
            done_reg <= (cnt_reg == STABLE_MAX);
            if (seg != seg_q) begin
                cnt_reg <= 8'd1;
            end else if (cnt_reg != STABLE_MAX) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    // Result buffer FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            valid_reg   <= 1'b0;
            digit_reg   <= 4'd0;
            err_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (emit) begin
                        state_reg <= ST_HOLD;
                        valid_reg <= 1'b1;
                        digit_reg <= dec_digit;
                        err_reg   <= dec_illegal;
                    end
                end
                ST_HOLD: begin
                    if (emit && out_if.out_ready) begin
                        // Current result is taken this cycle; replace it.
                        digit_reg <= dec_digit;
                        err_reg   <= dec_illegal;
                    end else if (emit) begin
                        // Consumer is stalled: keep the held result, drop the new one.
                        overrun_reg <= 1'b1;
                    end else if (out_if.out_ready) begin
                        state_reg <= ST_IDLE;
                        valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.out_valid = valid_reg;
    assign out_if.digit     = digit_reg;
    assign out_if.out_err   = err_reg;
    assign out_if.overrun   = overrun_reg;

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples needed before a pattern is decoded (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have port seg, input, 7 bits: segment lines A..G with A = bit 6 and G = bit 0; 1 = lit.
REQ-005 SHALL have port out_valid, output, 1 bit: the decoded result is available.
REQ-006 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-007 SHALL have port digit, output, 4 bits: the decoded value; 0 when out_err = 1.
REQ-008 SHALL have port out_err, output, 1 bit: the qualified pattern is illegal.
REQ-009 SHALL have port overrun, output, 1 bit: a one-cycle pulse when a result is dropped.

Function
REQ-010 SHALL register seg into seg_q every cycle (one sample stage); all decisions use seg_q.
REQ-011 SHALL keep a stability counter that resets to 1 when seg_q differs from its previous value, increments otherwise, and saturates at STABLE_CYCLES.
REQ-012 SHALL qualify a pattern on the cycle the counter first reaches STABLE_CYCLES; a pattern held indefinitely SHALL qualify exactly once.
REQ-013 SHALL assert out_valid on the 5th rising edge after seg changes to a new stable value (STABLE_CYCLES+1 edges in general).
REQ-014 SHALL decode qualified patterns as follows: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1110001=7 (variant emitted by the team's driver), 1111111=8, 1111011=9.
REQ-015 SHALL treat a qualified blank pattern (0000000) as no emission and SHALL re-arm, so that the same digit after a blank is emitted again.
REQ-016 SHALL emit any other qualified pattern with out_err=1 and digit=0.
REQ-017 SHALL implement states IDLE (no result held) and HOLD (out_valid=1); IDLE goes to HOLD on a non-blank qualification; HOLD goes to IDLE when out_ready=1 and no new qualification occurs.
REQ-018 SHALL keep digit and out_err stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, when qualification and out_ready=1 coincide in HOLD, load the new result and stay in HOLD with no overrun.
REQ-020 SHALL, when qualification occurs in HOLD with out_ready=0, discard the new result, keep the held one, and pulse overrun for one cycle.

Reset
REQ-021 SHALL, while rst_n=0, force out_valid=0, digit=0, out_err=0, overrun=0, seg_q=0, counter=0, and state IDLE.
REQ-022 SHALL, on reset mid-HOLD, drop the held result with no overrun pulse.
REQ-023 SHALL, after reset release, treat the first sampled non-zero pattern as a change that requires full qualification.

Configuration
REQ-024 SHALL, with SEG7_READER_HEX_EN defined, additionally decode 1110111=A, 0011111=b, 1001110=C, 0111101=d, 1001111=E, 1000111=F as 10..15 with out_err=0.
REQ-025 SHALL, without SEG7_READER_HEX_EN, report those six patterns as out_err=1, digit=0.

Structure
REQ-026 SHALL place the segment-pattern constants, the state enum, and the 4-bit digit type in package seg7_pkg.
REQ-027 SHALL implement the pattern-to-digit lookup as the combinational sub-module seg7_pattern_decode (ports: pattern in, digit out, illegal out); the FSM, counter, and buffer SHALL stay in seg7_reader.

Verification
REQ-028 SHALL cover: seg=1101101 held 10 cycles, out_ready=1 -> out_valid high for exactly 1 cycle, 5 edges after the change, with digit=2 and out_err=0.
REQ-029 SHALL cover: seg toggling 1111110/0110000 every 2 cycles, then 0110000 held -> exactly one result, digit=1.
REQ-030 SHALL cover: 1111001 qualified with out_ready=0, then 1011011 qualified -> digit stays 3, one overrun pulse; out_ready=1 -> 3 is accepted and 5 is never emitted.
REQ-031 SHALL cover: 1111111 qualified, then 0000000 qualified, then 1111111 qualified (out_ready=1) -> two results with digit=8 and no result for the blank.
REQ-032 SHALL cover: 1110111 qualified -> digit=10, out_err=0 with SEG7_READER_HEX_EN defined; digit=0, out_err=1 without it.
REQ-033 SHALL cover: rst_n pulsed low during HOLD with digit=9 -> out_valid=0 immediately (asynchronous), no overrun, then 9 re-qualifies 5 edges after release.
